// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, widths and control payload for the pipeline hazard/flow controller.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_XLEN   = 32;
  localparam int unsigned CTRL_REG_AW = 5;
  localparam int unsigned CTRL_CNT_W  = 32;
  localparam int unsigned CTRL_FCNT_W = 3;

  localparam logic [CTRL_XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_FLUSH = 2'd1,
    CTRL_STALL = 2'd2,
    CTRL_HALT  = 2'd3
  } ctrl_state_e;

  // Per-cycle pipeline control bundle driven into pc_reg, if_id and id_ex.
  typedef struct packed {
    logic                 pc_jump_en;
    logic [CTRL_XLEN-1:0] pc_jump_addr;
    logic                 hold_pc;
    logic                 hold_if_id;
    logic                 hold_id_ex;
    logic                 flush_if_id;
    logic                 flush_id_ex;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in id_ex whose rd feeds the instruction in decode.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                   idex_load_i,
  input  logic [CTRL_REG_AW-1:0] idex_rd_i,
  input  logic [CTRL_REG_AW-1:0] id_rs1_i,
  input  logic [CTRL_REG_AW-1:0] id_rs2_i,
  output logic                   hazard_c
);

  // x0 is never a real dependency, so rd==0 never raises a hazard.
  always_comb begin
    hazard_c = idex_load_i && (idex_rd_i != '0) &&
               ((idex_rd_i == id_rs1_i) || (idex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard and flow controller for the IF/ID/EX pipeline.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = CTRL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jump_en_i,
  input  logic [CTRL_XLEN-1:0]   jump_addr_i,
  input  logic                   busy_i,
  input  logic                   idex_load_i,
  input  logic [CTRL_REG_AW-1:0] idex_rd_i,
  input  logic [CTRL_REG_AW-1:0] id_rs1_i,
  input  logic [CTRL_REG_AW-1:0] id_rs2_i,
  input  logic                   halt_req_i,
  output logic                   pc_jump_en_o,
  output logic [CTRL_XLEN-1:0]   pc_jump_addr_o,
  output logic                   hold_pc_o,
  output logic                   hold_if_id_o,
  output logic                   hold_id_ex_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_ex_o,
  output logic                   halt_ack_o,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       stall_cycles_o,
  output logic [CNT_W-1:0]       flush_events_o
);

  ctrl_state_e            state_q, state_d;
  logic [CTRL_FCNT_W-1:0] cnt_q, cnt_d;
  logic                   halt_ack_q;
  logic [CNT_W-1:0]       stall_q, flush_ev_q;
  ctrl_t                  ctrl;
  logic                   jump_acc;
  logic                   hazard_c;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .idex_load_i (idex_load_i),
    .idex_rd_i   (idex_rd_i),
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .hazard_c    (hazard_c)
  );

  // State, flush countdown, halt acknowledge and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CTRL_RUN;
      cnt_q      <= '0;
      halt_ack_q <= 1'b0;
      stall_q    <= '0;
      flush_ev_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halt_ack_q <= (state_d == CTRL_HALT);
      stall_q    <= stall_q + CNT_W'(ctrl.hold_pc);
      flush_ev_q <= flush_ev_q + CNT_W'(jump_acc);
    end
  end

  // Next state and per-cycle controls; priority jump > busy > halt > load-use.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = '0;
    jump_acc = 1'b0;

    if (state_q == CTRL_HALT) begin
      // Halted core: keep fetch frozen and feed bubbles; jump/busy are ignored.
      ctrl.hold_pc     = 1'b1;
      ctrl.hold_if_id  = 1'b1;
      ctrl.flush_id_ex = 1'b1;
      if (!halt_req_i) begin
        state_d = CTRL_RUN;
      end
    end else if (jump_en_i) begin
      jump_acc          = 1'b1;
      ctrl.pc_jump_en   = 1'b1;
      ctrl.pc_jump_addr = jump_addr_i;
      ctrl.flush_if_id  = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = CTRL_FLUSH;
        cnt_d   = CTRL_FCNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = CTRL_RUN;
        cnt_d   = '0;
      end
    end else if (busy_i) begin
      ctrl.hold_pc    = 1'b1;
      ctrl.hold_if_id = 1'b1;
      ctrl.hold_id_ex = 1'b1;
      state_d         = CTRL_STALL;
    end else begin
      case (state_q)
        CTRL_FLUSH: begin
          // Pending halt requests wait until the flush drains back to RUN.
          ctrl.flush_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
          cnt_d            = cnt_q - CTRL_FCNT_W'(1);
          if (cnt_q == CTRL_FCNT_W'(1)) begin
            state_d = CTRL_RUN;
          end
        end
        CTRL_STALL: begin
          state_d = CTRL_RUN;
        end
        default: begin
          if (halt_req_i) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            state_d          = CTRL_HALT;
          end else if (hazard_c) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
          end
        end
      endcase
    end

    if (!rst_n) begin
      ctrl     = '0;
      jump_acc = 1'b0;
    end
  end

  assign pc_jump_en_o   = ctrl.pc_jump_en;
  assign pc_jump_addr_o = ctrl.pc_jump_addr;
  assign hold_pc_o      = ctrl.hold_pc;
  assign hold_if_id_o   = ctrl.hold_if_id;
  assign hold_id_ex_o   = ctrl.hold_id_ex;
  assign flush_if_id_o  = ctrl.flush_if_id;
  assign flush_id_ex_o  = ctrl.flush_id_ex;
  assign halt_ack_o     = halt_ack_q;
  assign state_o        = state_q;
  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_ev_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl built with FLUSH_CYCLES=2, CNT_W=4.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jump_en_i;
  logic [31:0]   jump_addr_i;
  logic          busy_i;
  logic          idex_load_i;
  logic [4:0]    idex_rd_i, id_rs1_i, id_rs2_i;
  logic          halt_req_i;
  logic          pc_jump_en_o;
  logic [31:0]   pc_jump_addr_o;
  logic          hold_pc_o, hold_if_id_o, hold_id_ex_o;
  logic          flush_if_id_o, flush_id_ex_o;
  logic          halt_ack_o;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cycles_o, flush_events_o;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] sc, fe;
  logic [5:0]    outs;

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .busy_i         (busy_i),
    .idex_load_i    (idex_load_i),
    .idex_rd_i      (idex_rd_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .halt_req_i     (halt_req_i),
    .pc_jump_en_o   (pc_jump_en_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .halt_ack_o     (halt_ack_o),
    .state_o        (state_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_events_o (flush_events_o)
  );

  always #5 clk = ~clk;

  // {pc_jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
  assign outs = {pc_jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                 flush_if_id_o, flush_id_ex_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    jump_en_i = 1'b0; jump_addr_i = '0; busy_i = 1'b0; idex_load_i = 1'b0;
    idex_rd_i = '0; id_rs1_i = '0; id_rs2_i = '0; halt_req_i = 1'b0;
  endtask

  // Check controls/state mid-cycle, update the counter model, advance one clock.
  task automatic cyc(input string tag, input logic [5:0] eo, input logic [1:0] es);
    @(negedge clk);
    check({tag, ".outs"}, 64'(outs), 64'(eo));
    check({tag, ".state"}, 64'(state_o), 64'(es));
    sc = sc + CW'(eo[4]);
    fe = fe + CW'(eo[5]);
    @(posedge clk); #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, ".stall_cnt"}, 64'(stall_cycles_o), 64'(sc));
    check({tag, ".flush_cnt"}, 64'(flush_events_o), 64'(fe));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sc = '0; fe = '0;
    idle();
    rst_n = 1'b0;
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100; busy_i = 1'b1; halt_req_i = 1'b1;
    #2;
    check("rst.outs", 64'(outs), 64'h0);
    check("rst.addr", 64'(pc_jump_addr_o), 64'h0);
    check("rst.state", 64'(state_o), 64'(CTRL_RUN));
    check("rst.ack", 64'(halt_ack_o), 64'h0);
    check_cnt("rst");
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;

    cyc("idle", 6'b000000, CTRL_RUN);

    // Jump with a two-cycle flush
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
    #1 check("jmp.addr", 64'(pc_jump_addr_o), 64'h100);
    cyc("jmp0", 6'b100011, CTRL_RUN);
    idle();
    cyc("jmp1", 6'b000011, CTRL_FLUSH);
    cyc("jmp2", 6'b000000, CTRL_RUN);
    check_cnt("jmp");
    check("jmp.fe_is_1", 64'(flush_events_o), 64'h1);

    // Busy for three cycles
    busy_i = 1'b1;
    cyc("busy0", 6'b011100, CTRL_RUN);
    cyc("busy1", 6'b011100, CTRL_STALL);
    cyc("busy2", 6'b011100, CTRL_STALL);
    busy_i = 1'b0;
    cyc("busy3", 6'b000000, CTRL_STALL);
    cyc("busy4", 6'b000000, CTRL_RUN);
    check("busy.sc_is_3", 64'(stall_cycles_o), 64'h3);

    // Jump arriving in the second busy cycle wins
    busy_i = 1'b1;
    cyc("bj0", 6'b011100, CTRL_RUN);
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
    #1 check("bj.addr", 64'(pc_jump_addr_o), 64'h200);
    cyc("bj1", 6'b100011, CTRL_STALL);
    idle();
    cyc("bj2", 6'b000011, CTRL_FLUSH);
    cyc("bj3", 6'b000000, CTRL_RUN);
    check_cnt("bj");

    // Load-use hazards
    idex_load_i = 1'b1; idex_rd_i = 5'd5; id_rs1_i = 5'd1; id_rs2_i = 5'd5;
    cyc("lu_rs2", 6'b011001, CTRL_RUN);
    idex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    cyc("lu_x0", 6'b000000, CTRL_RUN);
    idex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs2_i = 5'd3;
    cyc("lu_rs1", 6'b011001, CTRL_RUN);
    idex_load_i = 1'b0;
    cyc("lu_noload", 6'b000000, CTRL_RUN);
    idex_load_i = 1'b1; idex_rd_i = 5'd9; id_rs1_i = 5'd8; id_rs2_i = 5'd10;
    cyc("lu_nomatch", 6'b000000, CTRL_RUN);
    idle();
    check_cnt("lu");

    // Halt requested for five cycles; jump/busy ignored once halted
    halt_req_i = 1'b1;
    #1 check("h1.ack", 64'(halt_ack_o), 64'h0);
    cyc("h1", 6'b011001, CTRL_RUN);
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300; busy_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1 check($sformatf("h%0d.ack", i), 64'(halt_ack_o), 64'h1);
      cyc($sformatf("h%0d", i), 6'b011001, CTRL_HALT);
    end
    idle();
    #1 check("h6.ack", 64'(halt_ack_o), 64'h1);
    cyc("h6", 6'b011001, CTRL_HALT);
    #1 check("h7.ack", 64'(halt_ack_o), 64'h0);
    cyc("h7", 6'b000000, CTRL_RUN);
    check_cnt("halt");

    // Halt raised during STALL is taken only after returning to RUN
    busy_i = 1'b1;
    cyc("hs0", 6'b011100, CTRL_RUN);
    busy_i = 1'b0; halt_req_i = 1'b1;
    cyc("hs1", 6'b000000, CTRL_STALL);
    cyc("hs2", 6'b011001, CTRL_RUN);
    halt_req_i = 1'b0;
    cyc("hs3", 6'b011001, CTRL_HALT);
    cyc("hs4", 6'b000000, CTRL_RUN);

    // Halt raised during FLUSH waits for the flush to finish
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0400;
    cyc("hf0", 6'b100011, CTRL_RUN);
    jump_en_i = 1'b0; halt_req_i = 1'b1;
    cyc("hf1", 6'b000011, CTRL_FLUSH);
    cyc("hf2", 6'b011001, CTRL_RUN);
    halt_req_i = 1'b0;
    cyc("hf3", 6'b011001, CTRL_HALT);
    cyc("hf4", 6'b000000, CTRL_RUN);
    check_cnt("hf");

    // Drive the 4-bit stall counter to 15, then wrap through 0 to 1
    idex_load_i = 1'b1; idex_rd_i = 5'd4; id_rs1_i = 5'd4;
    for (int i = 0; i < 16 && sc != 4'hF; i++) cyc("wr_fill", 6'b011001, CTRL_RUN);
    check("wr.sc_15", 64'(stall_cycles_o), 64'hF);
    cyc("wr_a", 6'b011001, CTRL_RUN);
    check("wr.sc_0", 64'(stall_cycles_o), 64'h0);
    cyc("wr_b", 6'b011001, CTRL_RUN);
    check("wr.sc_1", 64'(stall_cycles_o), 64'h1);
    idle();

    // Reset asserted mid-FLUSH
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0500;
    cyc("rf0", 6'b100011, CTRL_RUN);
    idle();
    #1 check("rf.state_flush", 64'(state_o), 64'(CTRL_FLUSH));
    rst_n = 1'b0;
    #1;
    check("rf.state", 64'(state_o), 64'(CTRL_RUN));
    check("rf.outs", 64'(outs), 64'h0);
    check("rf.ack", 64'(halt_ack_o), 64'h0);
    sc = '0; fe = '0;
    check_cnt("rf");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("rf_run", 6'b000000, CTRL_RUN);
    check_cnt("rf_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
